// File: rtl/bcd_pkg.sv
// bcd_pkg: shared constants and helpers for the BCD scan counter.
//
// Contents:
//   BCD_MAX        largest legal BCD digit (9)
//   BCD_MIN        smallest legal BCD digit (0)
//   bcd_sanitize   maps a nibble greater than 9 to 0, passes 0..9 through
package bcd_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

  function automatic logic [3:0] bcd_sanitize(input logic [3:0] nibble);
    return (nibble > BCD_MAX) ? BCD_MIN : nibble;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one decade of the BCD up/down counter.
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   load        synchronous load strobe; wins over step
//   load_nib    nibble to load; values above 9 load as 0
//   step        advance this digit by one in direction up
//   up          1 = increment, 0 = decrement (only looked at when step is set)
//   q           current digit value
//   wrap        combinational: step is set and the digit is about to roll
//               over (9 going up, 0 going down); feeds the next digit's step
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_nib,
  input  logic       step,
  input  logic       up,
  output logic [3:0] q,
  output logic       wrap
);

  assign wrap = step && (up ? (q == BCD_MAX) : (q == BCD_MIN));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= BCD_MIN;
    end else if (load) begin
      q <= bcd_sanitize(load_nib);
    end else if (step) begin
      if (up) begin
        q <= (q == BCD_MAX) ? BCD_MIN : q + 4'd1;
      end else begin
        q <= (q == BCD_MIN) ? BCD_MAX : q - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_scan_counter.sv
// bcd_scan_counter: multi-digit BCD up/down counter with a tick prescaler
// and a time-multiplexed digit scanner for a shared-segment display.
//
// Parameters:
//   DIGITS    number of BCD digits (1..8)
//   TICK_DIV  clock cycles per count step (>= 2)
//   SCAN_DIV  clock cycles per scan slot (>= 2)
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   en          count enable; low freezes prescaler and count
//   up          count direction, sampled on the tick cycle only
//   load        synchronous load strobe (beats a coincident tick)
//   load_val    BCD value to load, digit 0 in the LSBs
//   count       current BCD count
//   carry       one-cycle pulse coincident with a full wrap of count
//   scan_bcd    nibble of the digit currently selected
//   scan_sel    one-hot active-low digit enable
module bcd_scan_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS   = 2,
  parameter int TICK_DIV = 50_000,
  parameter int SCAN_DIV = 1_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                up,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] count,
  output logic                carry,
  output logic [3:0]          scan_bcd,
  output logic [DIGITS-1:0]   scan_sel
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $error("bcd_scan_counter: DIGITS must be 1..8");
  end
  if (TICK_DIV < 2) begin : g_bad_tick
    $error("bcd_scan_counter: TICK_DIV must be >= 2");
  end
  if (SCAN_DIV < 2) begin : g_bad_scan
    $error("bcd_scan_counter: SCAN_DIV must be >= 2");
  end

  // ---------------------------------------------------------------------
  // Prescaler
  // ---------------------------------------------------------------------
  logic [PW-1:0] pcnt;
  logic          tick;

  assign tick = en && (pcnt == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
    end else if (load) begin
      // A load restarts the step interval, even with en low.
      pcnt <= '0;
    end else if (en) begin
      pcnt <= tick ? '0 : pcnt + PW'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Digit chain: each digit steps only when every lower digit is wrapping
  // on this tick, which gives the decimal ripple in both directions.
  // ---------------------------------------------------------------------
  logic [DIGITS-1:0] step;
  logic [DIGITS-1:0] wrap;

  assign step[0] = tick;

  for (genvar k = 1; k < DIGITS; k++) begin : g_step
    assign step[k] = tick && wrap[k-1];
  end

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    bcd_digit u_digit (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .load_nib (load_val[4*k +: 4]),
      .step     (step[k]),
      .up       (up),
      .q        (count[4*k +: 4]),
      .wrap     (wrap[k])
    );
  end

  // ---------------------------------------------------------------------
  // Carry: all digits wrapping at once means the whole count rolls over.
  // The load term keeps a coincident tick from pulsing carry when the
  // load has already overridden the step.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry <= 1'b0;
    end else begin
      carry <= !load && (&wrap);
    end
  end

  // ---------------------------------------------------------------------
  // Scanner: free-running, independent of en and load.
  // scan_sel and scan_bcd are registered from the next slot index so that
  // scan_sel always equals ~(1 << sidx) and both outputs move on the same
  // edge; scan_bcd samples the count register, hence one cycle behind it.
  // ---------------------------------------------------------------------
  logic [SW-1:0] scnt;
  logic [IW-1:0] sidx;
  logic [IW-1:0] sidx_next;
  logic          scan_wrap;
  logic [3:0]    sel_nib;

  assign scan_wrap = (scnt == SW'(SCAN_DIV - 1));

  always_comb begin
    sidx_next = sidx;
    if (scan_wrap) begin
      sidx_next = (sidx == IW'(DIGITS - 1)) ? '0 : sidx + IW'(1);
    end
  end

  always_comb begin
    sel_nib = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (sidx_next == IW'(k)) begin
        sel_nib = count[4*k +: 4];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scnt     <= '0;
      sidx     <= '0;
      scan_bcd <= BCD_MIN;
      scan_sel <= ~DIGITS'(1);
    end else begin
      scnt     <= scan_wrap ? '0 : scnt + SW'(1);
      sidx     <= sidx_next;
      scan_bcd <= sel_nib;
      scan_sel <= ~(DIGITS'(1) << sidx_next);
    end
  end

endmodule

// File: tb/tb_bcd_scan_counter.sv
// tb_bcd_scan_counter: directed bench for bcd_scan_counter with
// DIGITS=2, TICK_DIV=4, SCAN_DIV=3. A value-level model (count held as an
// integer, scanner as an elapsed-cycle count) is compared against the DUT
// every cycle out of reset, plus hand-computed literal expectations.
module tb_bcd_scan_counter;

  localparam int DIGITS   = 2;
  localparam int TICK_DIV = 4;
  localparam int SCAN_DIV = 3;
  localparam int MAXV     = 99;

  logic                clk;
  logic                rst_n;
  logic                en;
  logic                up;
  logic                load;
  logic [4*DIGITS-1:0] load_val;
  logic [4*DIGITS-1:0] count;
  logic                carry;
  logic [3:0]          scan_bcd;
  logic [DIGITS-1:0]   scan_sel;

  int checks = 0;
  int errors = 0;

  bcd_scan_counter #(
    .DIGITS   (DIGITS),
    .TICK_DIV (TICK_DIV),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .carry    (carry),
    .scan_bcd (scan_bcd),
    .scan_sel (scan_sel)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic int pow10(input int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
    logic [4*DIGITS-1:0] r = '0;
    for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
    return r;
  endfunction

  function automatic int from_load(input logic [4*DIGITS-1:0] lv);
    int v = 0;
    int d;
    for (int i = 0; i < DIGITS; i++) begin
      d = int'(lv[4*i +: 4]);
      if (d > 9) d = 0;
      v = v + d * pow10(i);
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_load(input logic [4*DIGITS-1:0] v);
    load     = 1'b1;
    load_val = v;
    cyc(1);
    load     = 1'b0;
  endtask

  // ---------------- behavioural model ----------------
  int                m_val   = 0;    // count as a plain integer
  int                m_pc    = 0;    // cycles into the current step interval
  int                m_scyc  = 0;    // edges since reset release
  logic              m_carry = 1'b0;
  logic [DIGITS-1:0] m_sel   = 2'b10;
  logic [3:0]        m_bcd   = 4'd0;

  always @(posedge clk or negedge rst_n) begin
    int  old_val;
    int  slot;
    bit  tk;
    if (!rst_n) begin
      m_val = 0; m_pc = 0; m_scyc = 0;
      m_carry = 1'b0; m_sel = 2'b10; m_bcd = 4'd0;
    end else begin
      old_val = m_val;
      tk      = en && (m_pc == TICK_DIV - 1);
      m_carry = 1'b0;
      if (load) begin
        m_val = from_load(load_val);
        m_pc  = 0;
      end else begin
        if (en) m_pc = tk ? 0 : m_pc + 1;
        if (tk) begin
          if (up) begin
            if (m_val == MAXV) begin m_val = 0; m_carry = 1'b1; end
            else m_val = m_val + 1;
          end else begin
            if (m_val == 0) begin m_val = MAXV; m_carry = 1'b1; end
            else m_val = m_val - 1;
          end
        end
      end
      m_scyc = m_scyc + 1;
      slot   = (m_scyc / SCAN_DIV) % DIGITS;
      m_sel  = ~(DIGITS'(1) << slot);
      m_bcd  = 4'((old_val / pow10(slot)) % 10);
    end
  end

  // ---------------- scoreboard compare, every cycle out of reset ----------------
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      chk("model_count", 32'(count), 32'(to_bcd(m_val)));
      chk("model_carry", 32'(carry), 32'(m_carry));
      chk("model_sel", 32'(scan_sel), 32'(m_sel));
      chk("model_bcd", 32'(scan_bcd), 32'(m_bcd));
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    rst_n = 1'b0; en = 1'b1; up = 1'b1; load = 1'b0; load_val = '0;
    cyc(3);
    chk("rst_count", 32'(count), 32'h00);
    chk("rst_carry", 32'(carry), 32'h0);
    chk("rst_sel", 32'(scan_sel), 32'h2);
    chk("rst_bcd", 32'(scan_bcd), 32'h0);

    // 1. first steps after release land on edges 4 and 8
    rst_n = 1'b1;
    cyc(1);
    chk("post_rst_sel", 32'(scan_sel), 32'h2);
    cyc(2);
    chk("first_hold", 32'(count), 32'h00);
    cyc(1);
    chk("first_step", 32'(count), 32'h01);
    cyc(4);
    chk("second_step", 32'(count), 32'h02);

    // 2. up wrap
    do_load(8'h98);
    chk("load_98", 32'(count), 32'h98);
    cyc(4);
    chk("up_99", 32'(count), 32'h99);
    cyc(4);
    chk("up_wrap", 32'(count), 32'h00);
    chk("up_carry", 32'(carry), 32'h1);
    cyc(1);
    chk("up_carry_drop", 32'(carry), 32'h0);
    cyc(3);
    chk("up_01", 32'(count), 32'h01);
    chk("up_01_carry", 32'(carry), 32'h0);

    // 3. down wrap
    up = 1'b0;
    do_load(8'h10);
    chk("load_10", 32'(count), 32'h10);
    cyc(4);
    chk("down_09", 32'(count), 32'h09);
    cyc(36);
    chk("down_00", 32'(count), 32'h00);
    cyc(4);
    chk("down_wrap", 32'(count), 32'h99);
    chk("down_carry", 32'(carry), 32'h1);
    cyc(1);
    chk("down_carry_drop", 32'(carry), 32'h0);

    // 4. invalid nibble, then load colliding with a tick
    up = 1'b1;
    do_load(8'hA7);
    chk("load_a7", 32'(count), 32'h07);
    cyc(3);
    do_load(8'h99);
    chk("load_vs_tick", 32'(count), 32'h99);
    chk("load_vs_tick_carry", 32'(carry), 32'h0);
    cyc(3);
    chk("after_load_hold", 32'(count), 32'h99);
    cyc(1);
    chk("after_load_step", 32'(count), 32'h00);
    chk("after_load_carry", 32'(carry), 32'h1);

    // 5. freeze with the prescaler part-way through an interval
    do_load(8'h34);
    cyc(2);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      chk("freeze_count", 32'(count), 32'h34);
      if (scan_sel == 2'b10) chk("freeze_bcd0", 32'(scan_bcd), 32'h4);
      else begin
        chk("freeze_sel", 32'(scan_sel), 32'h1);
        chk("freeze_bcd1", 32'(scan_bcd), 32'h3);
      end
    end
    en = 1'b1;
    cyc(1);
    chk("thaw_hold", 32'(count), 32'h34);
    cyc(1);
    chk("thaw_step", 32'(count), 32'h35);

    // 6. asynchronous reset between edges
    do_load(8'h57);
    cyc(2);
    chk("pre_async", 32'(count), 32'h57);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_count", 32'(count), 32'h00);
    chk("async_carry", 32'(carry), 32'h0);
    chk("async_sel", 32'(scan_sel), 32'h2);
    chk("async_bcd", 32'(scan_bcd), 32'h0);
    cyc(1);
    rst_n = 1'b1;
    cyc(3);
    chk("rerst_hold", 32'(count), 32'h00);
    cyc(1);
    chk("rerst_step", 32'(count), 32'h01);
    chk("rerst_carry", 32'(carry), 32'h0);
    cyc(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_scan_counter.md
# bcd_scan_counter

Multi-digit BCD up/down counter with tick prescaler and time-multiplexed digit scanner. It drives the 4-bit input of the seven-segment decoder and provides the active-low digit-enable lines for a shared-segment display. Two instances of that decoder are not needed: one decoder sits on `scan_bcd`, and the anodes are driven directly from `scan_sel`.

## Interface
- `DIGITS`, default 2: number of BCD digits. Legal range is 1–8.
- `TICK_DIV`, default 50_000: clock cycles per count step. Must be ≥ 2.
- `SCAN_DIV`, default 1_000: clock cycles per scan slot. Must be ≥ 2.

Ports:
- `clk`, input, 1: system clock. The block uses one clock domain.
- `rst_n`, input, 1: asynchronous active-low reset.
- `en`, input, 1: count enable. When low, the prescaler and the count freeze.
- `up`, input, 1: direction. 1 counts up, 0 counts down.
- `load`, input, 1: synchronous load strobe.
- `load_val`, input, 4*DIGITS: BCD value to load. Digit 0 is in the LSBs.
- `count`, output, 4*DIGITS: current BCD count, registered.
- `carry`, output, 1: one-cycle wrap pulse.
- `scan_bcd`, output, 4: BCD nibble of the currently scanned digit.
- `scan_sel`, output, DIGITS: one-hot active-low digit enable.

## Operation
- **Prescaler:**
  - `pcnt` counts from 0 to TICK_DIV-1 while `en`=1, then wraps.
  - `tick` is asserted when `pcnt`==TICK_DIV-1 and `en`=1.
  - While `en`=0, `pcnt` holds its value.
- **Priority per cycle:** reset > `load` > `tick` > hold.
- **Load:**
  - `count` ← `load_val` on the next edge. Any nibble greater than 9 is replaced by 0.
  - `pcnt` ← 0.
  - `carry` = 0 in that cycle, even if a tick coincides.
- **Count up on tick:**
  - Digit 0 increments.
  - A digit that was 9 becomes 0 and increments the next digit (ripple).
  - When all digits are 9, the count wraps to all 0 and `carry` pulses.
- **Count down on tick:**
  - A digit that was 0 becomes 9 and borrows from the next digit.
  - When all digits are 0, the count wraps to all 9 and `carry` pulses.
- **Direction:** `up` is sampled only on the tick cycle. A direction change between ticks has no other effect.
- **Scanner:**
  - Independent of `en` and `load`. It always runs.
  - `scnt` counts from 0 to SCAN_DIV-1. At wrap, `sidx` advances 0→1→…→DIGITS-1→0.
  - `scan_sel` = ~(1<<`sidx`).
  - `scan_bcd` = `count` nibble [`sidx`].
  - Both outputs are registered, so they always change on the same edge.
- **Single-digit case:** with DIGITS=1, `scan_sel` is constantly 0 and `scan_bcd` follows `count`.

## Timing
- **Reset values (asynchronous on `rst_n` low):**
  - `count` = 0, `carry` = 0.
  - `pcnt` = 0, `scnt` = 0, `sidx` = 0.
  - `scan_bcd` = 0.
  - `scan_sel` = all ones except bit 0 = 0.
- **Count latency:** `count` changes on the edge that ends the tick cycle. The first step after reset with `en`=1 appears TICK_DIV cycles after reset release.
- **Carry:**
  - Registered. High for exactly one cycle, coincident with the wrapped `count` value.
  - Never high for two consecutive cycles.
- **Scanner latency:** `scan_bcd` reflects `count` with one cycle of latency. A count change becomes visible on `scan_bcd` one edge later if that digit is currently selected.
- **Scan period:** each digit is selected for exactly SCAN_DIV cycles. The full frame is DIGITS×SCAN_DIV cycles.
- **Reset mid-operation:** all state returns to reset values immediately. No pulse is emitted on `carry` after release.
- **Load and en:** `load` with `en`=0 still loads and clears `pcnt`.

## Structure
- **Package `bcd_pkg`:**
  - Constants `BCD_MAX`=4'd9 and `BCD_MIN`=4'd0.
  - A function `bcd_sanitize(nibble)` that maps values greater than 9 to 0.
- **Sub-module `bcd_digit`:** one digit cell, generated DIGITS times.
  - Inputs: `clk`, `rst_n`, `load`, `load_nib`, `step`, `up`.
  - Outputs: `q[3:0]`, plus `wrap`, which is combinational and asserted when `step` is set and `q` is 9 (up) or 0 (down).
  - `step` of digit k = `tick` AND `wrap` of digit k-1. Digit 0 receives `tick`.
- **Top level:** holds the prescaler, the scanner and the carry register. `carry` = registered AND of all `wrap` signals.

## Test plan
Bench parameters: DIGITS=2, TICK_DIV=4, SCAN_DIV=3.

1. **Reset:** release `rst_n` with `en`=1, `up`=1. Expect `count` = 0x00 until cycle 4, 0x01 at cycle 4 and 0x02 at cycle 8. `scan_sel` = 2'b10 right after reset.
2. **Up wrap:** load 0x98, then run. Expect 0x99, then 0x00 with `carry` = 1 for one cycle, then 0x01 with `carry` = 0.
3. **Down wrap:** load 0x10 with `up`=0. Expect 0x09, then 0x00, then 0x99 with a `carry` pulse.
4. **Invalid load:** load 0xA7. Expect `count` = 0x07. Assert `load` in the same cycle as a tick: the load wins, `carry` = 0, and the next step comes 4 cycles later.
5. **Freeze:**
   - Deassert `en` for 10 cycles. `count` and `pcnt` must hold.
   - The scanner must keep rotating: `scan_sel` goes 10→01→10 every 3 cycles.
   - `scan_bcd` = nibble 0 while `scan_sel` = 10 and nibble 1 while `scan_sel` = 01.
6. **Asynchronous reset:** assert `rst_n` low between clock edges at `count` = 0x57. All outputs reach their reset values immediately, without waiting for a clock edge.
